// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the SISC fetch unit:
// opcodes, instruction field positions, PC width, FSM states.
package fetch_unit_pkg;

    localparam int PC_W = 16;
    localparam int IR_W = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        NOOP = 4'h0,
        LOD  = 4'h1,
        STR  = 4'h2,
        SWP  = 4'h3,
        BRA  = 4'h4,
        BRR  = 4'h5,
        BNE  = 4'h6,
        BNR  = 4'h7,
        ALU  = 4'h8,
        HLT  = 4'hF
    } sisc_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC select:
// PC+1, absolute imm, or PC-relative imm (mod 2^16).
module pc_reg
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic [PC_W-1:0] imm,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;

    // Two's-complement imm wraps naturally in the 16-bit add.
    always_comb begin
        w_pc_nxt = r_pc + PC_W'(1);
        if (pc_sel) begin
            w_pc_nxt = br_sel ? (r_pc + imm) : imm;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_pc <= '0;
        end else if (pc_rst) begin
            r_pc <= '0;
        end else if (pc_write) begin
            r_pc <= w_pc_nxt;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: req/ack fetch FSM, IR,
// status register and the PC sub-block.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            stat_en,
    input  logic [3:0]      stat_in,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic [3:0]      stat,
    output logic [PC_W-1:0] pc,
    output logic            ir_valid,
    output logic            fetch_busy
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic            w_start;
    logic            w_done;
    logic [PC_W-1:0] r_addr;
    logic [IR_W-1:0] r_ir;
    logic            r_valid;
    logic [3:0]      r_stat;
    logic [PC_W-1:0] w_pc;
    logic            w_unused_ir;

    pc_reg u_pc_reg (
        .clk      (clk),
        .rst_f    (rst_f),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .imm      (r_ir[IMM_MSB:IMM_LSB]),
        .pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ir_load is only heard in IDLE, imem_ack only in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (ir_load) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_addr  <= '0;
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= w_pc;
                r_valid <= 1'b0;
            end
            if (w_done) begin
                r_ir    <= imem_rdata;
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_stat <= '0;
        end else if (stat_en) begin
            r_stat <= stat_in;
        end
    end

    assign imem_req    = (r_state == ST_WAIT);
    assign fetch_busy  = (r_state == ST_WAIT);
    assign imem_addr   = r_addr;
    assign opcode      = r_ir[OPC_MSB:OPC_LSB];
    assign mm          = r_ir[MM_MSB:MM_LSB];
    assign imm         = r_ir[IMM_MSB:IMM_LSB];
    assign stat        = r_stat;
    assign pc          = w_pc;
    assign ir_valid    = r_valid;
    assign w_unused_ir = ^r_ir[MM_LSB-1:IMM_MSB+1];

endmodule
